// File: rtl/gps_uart_top.sv
// GPS-to-FTDI UART bridge: receives 8N1 bytes from the GPS into a small FIFO
// and replays them to the FTDI link once the GPS line has been idle long enough.
module gps_uart_top #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int GPS_BAUD  = 9600,
  parameter int FTDI_BAUD = 115_200,
  parameter int DATA_BITS = 8,
  parameter int MEM_DEPTH = 10,
  parameter int IDLE_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_gps,
  output logic tx_gps,
  input  logic rx_ftdi,
  output logic tx_ftdi
);
  localparam int RX_BIT   = CLK_FREQ / GPS_BAUD;
  localparam int TX_BIT   = CLK_FREQ / FTDI_BAUD;
  localparam int IDLE_MAX = IDLE_BITS * RX_BIT;
  localparam int RX_CW    = $clog2(RX_BIT);
  localparam int TX_CW    = $clog2(TX_BIT);
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int PTR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W    = $clog2(MEM_DEPTH + 1);
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [RX_CW-1:0]  RX_LAST  = RX_CW'(RX_BIT - 1);
  localparam logic [RX_CW-1:0]  RX_HALF  = RX_CW'(RX_BIT / 2 - 1);
  localparam logic [TX_CW-1:0]  TX_LAST  = TX_CW'(TX_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(MEM_DEPTH);
  localparam logic [IDLE_W-1:0] IDLE_TOP = IDLE_W'(IDLE_MAX);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic unused_rx_ftdi;
  assign unused_rx_ftdi = rx_ftdi;
  assign tx_gps = 1'b1;

  // Synchronizer plus one extra stage for falling-edge detection.
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_gps;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  rx_state_e            rx_state_q, rx_state_d;
  logic [RX_CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_valid_q, rx_valid_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == RX_HALF) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == RX_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == RX_LAST) begin
        rx_valid_d = rx_s2_q;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // push: one-cycle strobe, taken only when not full. pop: one-cycle strobe
  // from the TX FSM, only issued when not empty. Both may coincide.
  logic [DATA_BITS-1:0] mem_q [MEM_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 full, empty, push, pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign push  = rx_valid_q && !full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  tx_state_e            tx_state_q, tx_state_d;
  logic [TX_CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 flush_q, flush_d;

  always_comb begin
    idle_d  = idle_q;
    flush_d = flush_q;
    if (push || !rx_s2_q || rx_state_q != RX_IDLE) idle_d = '0;
    else if (idle_q != IDLE_TOP)                   idle_d = idle_q + 1'b1;
    if (!flush_q && idle_q == IDLE_TOP && !empty)                   flush_d = 1'b1;
    else if (flush_q && empty && !push && tx_state_q == TX_IDLE)    flush_d = 1'b0;
  end

  // The line level is registered from the next state so each bit lasts exactly TX_BIT cycles.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    pop        = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (flush_q && !empty) begin
          pop        = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q];
          tx_bit_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == TX_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == TX_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == BIT_LAST) begin
          tx_state_d = TX_STOP;
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 1'b1;
        end
      end
      TX_STOP: if (tx_cnt_q == TX_LAST) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_state_d == TX_START)     tx_d = 1'b0;
    else if (tx_state_d == TX_DATA) tx_d = tx_shift_d[0];
    else                            tx_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      idle_q     <= '0;
      flush_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      idle_q     <= idle_d;
      flush_q    <= flush_d;
    end
  end

  assign tx_ftdi = tx_q;

endmodule

// File: tb/tb_gps_uart_top.sv
// Bench for gps_uart_top with scaled baud rates: RX_BIT = 16, TX_BIT = 4 cycles.
module tb_gps_uart_top;
  localparam int CLK_FREQ  = 160;
  localparam int GPS_BAUD  = 10;
  localparam int FTDI_BAUD = 40;
  localparam int MEM_DEPTH = 10;
  localparam int IDLE_BITS = 2;
  localparam int RX_BIT    = CLK_FREQ / GPS_BAUD;
  localparam int TX_BIT    = CLK_FREQ / FTDI_BAUD;
  localparam int IDLE_MAX  = IDLE_BITS * RX_BIT;
  localparam int FRAME     = 10 * TX_BIT + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_gps = 1'b1;
  logic rx_ftdi = 1'b1;
  logic tx_gps, tx_ftdi;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gps_uart_top #(
    .CLK_FREQ(CLK_FREQ), .GPS_BAUD(GPS_BAUD), .FTDI_BAUD(FTDI_BAUD),
    .DATA_BITS(8), .MEM_DEPTH(MEM_DEPTH), .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clk(clk), .rst(rst), .rx_gps(rx_gps), .tx_gps(tx_gps),
    .rx_ftdi(rx_ftdi), .tx_ftdi(tx_ftdi)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int burst_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // tx_ftdi frame decoder; samples each bit at its centre on the falling clock edge
  int         starts = 0;
  int         start_cyc[64];
  logic       mon_busy = 1'b0;
  logic       mon_prev = 1'b1;
  logic       gps_bad = 1'b0;
  int         mon_c = 0;
  logic [7:0] mon_got = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (tx_gps !== 1'b1) gps_bad = 1'b1;
      if (rst) begin
        mon_busy = 1'b0;
        mon_prev = 1'b1;
      end else if (!mon_busy) begin
        if (mon_prev && tx_ftdi === 1'b0) begin
          mon_busy = 1'b1;
          mon_c = 0;
          if (starts < 64) start_cyc[starts] = cyc;
          starts++;
        end
        mon_prev = tx_ftdi;
      end else begin
        mon_c++;
        if (mon_c % TX_BIT == TX_BIT / 2) begin
          if (mon_c / TX_BIT == 0) begin
            check("start_bit", tx_ftdi, 1'b0);
          end else if (mon_c / TX_BIT <= 8) begin
            mon_got[mon_c / TX_BIT - 1] = tx_ftdi;
          end else begin
            check("stop_bit", tx_ftdi, 1'b1);
            check("frame_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("tx_byte", mon_got, exp_q.pop_front());
            mon_busy = 1'b0;
            mon_prev = tx_ftdi;
          end
        end
      end
    end
  end

  // drivers
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_gps = 1'b0;
    repeat (RX_BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_gps = b[i];
      repeat (RX_BIT) @(negedge clk);
    end
    rx_gps = stop;
    repeat (RX_BIT) @(negedge clk);
    if (stop && burst_cnt < MEM_DEPTH) begin
      exp_q.push_back(b);
      burst_cnt++;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    burst_cnt = 0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (starts < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_frame_start", starts >= target, 1'b1);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] msg [10];
  int base, t_end, lat, rstarts;

  initial begin : stimulus
    msg = '{8'h24, 8'h47, 8'h50, 8'h52, 8'h4D, 8'h43, 8'h2C, 8'h31, 8'h0D, 8'h0A};

    // reset state
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("rst_tx_ftdi", tx_ftdi, 1'b1);
    check("rst_tx_gps", tx_gps, 1'b1);
    repeat (3) @(negedge clk);
    check("post_rst_tx_ftdi", tx_ftdi, 1'b1);

    // single byte and flush latency
    base = starts;
    send_byte(8'h41, 1'b1);
    t_end = cyc;
    wait_starts(base + 1, 4 * IDLE_MAX);
    lat = start_cyc[base] - t_end;
    check("flush_latency", (lat >= IDLE_MAX - RX_BIT) && (lat <= IDLE_MAX + 4), 1'b1);
    drain(2 * IDLE_MAX + 2 * FRAME);

    // full buffer, no output during reception, contiguous replay
    base = starts;
    for (int i = 0; i < 10; i++) send_byte(msg[i], 1'b1);
    check("quiet_while_rx", starts, base);
    drain(2 * IDLE_MAX + 12 * FRAME);
    check("burst_frames", starts - base, 10);
    check("burst_span", start_cyc[base + 9] - start_cyc[base], 9 * FRAME);

    // overflow: the 11th byte is dropped
    base = starts;
    for (int i = 0; i < 11; i++) send_byte(8'h30 + 8'(i), 1'b1);
    drain(2 * IDLE_MAX + 12 * FRAME);
    repeat (3 * IDLE_MAX + FRAME) @(negedge clk);
    check("overflow_frames", starts - base, 10);

    // framing error then a valid byte
    base = starts;
    send_byte(8'h55, 1'b0);
    rx_gps = 1'b1;
    repeat (RX_BIT) @(negedge clk);
    send_byte(8'hAA, 1'b1);
    drain(2 * IDLE_MAX + 2 * FRAME);
    repeat (3 * IDLE_MAX + FRAME) @(negedge clk);
    check("framing_frames", starts - base, 1);

    // short glitch shorter than half a bit
    base = starts;
    rx_gps = 1'b0;
    repeat (4) @(negedge clk);
    rx_gps = 1'b1;
    repeat (3 * IDLE_MAX + FRAME) @(negedge clk);
    check("glitch_frames", starts - base, 0);

    // reset during the third output frame
    base = starts;
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 1'b1);
    wait_starts(base + 3, 2 * IDLE_MAX + 4 * FRAME);
    repeat (3 * TX_BIT) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("tx_after_rst", tx_ftdi, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    burst_cnt = 0;
    rstarts = starts;
    repeat (3 * IDLE_MAX + 2 * FRAME) @(negedge clk);
    check("quiet_after_rst", starts, rstarts);
    send_byte(8'h5A, 1'b1);
    drain(2 * IDLE_MAX + 2 * FRAME);
    check("post_rst_frames", starts - rstarts, 1);

    check("tx_gps_idle", gps_bad, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
